pc_redirect_unit: RTL

- Parametrised successor to the dual-issue branch resolver / next-PC mux: owns the fetch PC register for an N-wide front end.
- Resolves branches and jumps across ISSUE_NUM decode slots, oldest slot first.
- Arbitrates next PC in priority order: trap redirect, decode redirect, fetch-queue-full hold, sequential advance.
- Tracks in-flight fetches that a redirect makes stale. Sits between decode (ID) and the instruction-fetch request port.

---
 rtl/pc_redirect_unit_pkg.sv | 32 +++
 rtl/pc_redirect_unit_branch_cond_eval.sv | 35 +++
 rtl/pc_redirect_unit.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pc_redirect_unit_pkg.sv
// Shared definitions for the fetch-PC redirect unit: branch condition codes,
// default geometry and reset PC, and the next-PC source encoding.
package pc_redirect_unit_pkg;

    localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
    localparam logic [2:0] FUNCT3_BNE  = 3'b001;
    localparam logic [2:0] FUNCT3_BLT  = 3'b100;
    localparam logic [2:0] FUNCT3_BGE  = 3'b101;
    localparam logic [2:0] FUNCT3_BLTU = 3'b110;
    localparam logic [2:0] FUNCT3_BGEU = 3'b111;

    localparam int ISSUE_NUM_DEFAULT = 2;
    localparam int FETCH_NUM_DEFAULT = 2;
    localparam int XLEN_DEFAULT      = 64;

    typedef logic [XLEN_DEFAULT-1:0] addr_t;

    localparam addr_t RST_PC_DEFAULT = 64'h0000_0000_8000_0000;

    typedef enum logic [2:0] {
        NONE = 3'd0,
        TRAP = 3'd1,
        ID   = 3'd2,
        HOLD = 3'd3,
        SEQ  = 3'd4
    } redirect_src_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pc_redirect_unit_branch_cond_eval.sv
// Evaluates one decode slot's conditional-branch outcome from funct3 and the
// two source operands; reserved condition codes resolve as not taken.
module branch_cond_eval
    import pc_redirect_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output logic            o_taken
);

    logic w_eq;
    logic w_lt;
    logic w_ltu;

    assign w_eq  = (i_rs1 == i_rs2);
    assign w_lt  = ($signed(i_rs1) < $signed(i_rs2));
    assign w_ltu = (i_rs1 < i_rs2);

    // Condition select
    always_comb begin
        case (i_funct3)
            FUNCT3_BEQ:  o_taken = w_eq;
            FUNCT3_BNE:  o_taken = ~w_eq;
            FUNCT3_BLT:  o_taken = w_lt;
            FUNCT3_BGE:  o_taken = ~w_lt;
            FUNCT3_BLTU: o_taken = w_ltu;
            FUNCT3_BGEU: o_taken = ~w_ltu;
            default:     o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC owner for an N-wide front end: resolves decode-slot control transfers,
// arbitrates the next PC, and marks responses from fetches made stale by a redirect.
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter int              ISSUE_NUM       = ISSUE_NUM_DEFAULT,
    parameter int              FETCH_NUM       = FETCH_NUM_DEFAULT,
    parameter int              XLEN            = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RST_PC          = XLEN'(RST_PC_DEFAULT),
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [ISSUE_NUM-1:0]           issue_en,
    input  logic [ISSUE_NUM-1:0]           is_b,
    input  logic [ISSUE_NUM-1:0]           is_j,
    input  logic [ISSUE_NUM-1:0]           is_jr,
    input  logic [ISSUE_NUM*3-1:0]         funct3,
    input  logic [ISSUE_NUM*XLEN-1:0]      slot_pc,
    input  logic [ISSUE_NUM*XLEN-1:0]      rs_data1,
    input  logic [ISSUE_NUM*XLEN-1:0]      rs_data2,
    input  logic [ISSUE_NUM*XLEN-1:0]      imm,
    input  logic                           trap_valid,
    input  logic [XLEN-1:0]                trap_pc,
    input  logic                           fifo_full,
    input  logic                           resp_valid,
    input  logic [$clog2(FETCH_NUM+1)-1:0] resp_cnt,
    input  logic                           imem_ready,
    output logic                           imem_req,
    output logic [XLEN-1:0]                fetch_pc,
    output logic                           resp_drop,
    output logic                           id_is_transfer,
    output logic [ISSUE_NUM-1:0]           kill_mask,
    output logic                           misalign,
    output logic [31:0]                    redirect_cnt
);

    localparam int              OW       = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4 * FETCH_NUM);
    localparam logic [XLEN-1:0] LSB_CLR  = {{(XLEN-1){1'b1}}, 1'b0};

    logic [XLEN-1:0]                r_pc;
    logic [OW-1:0]                  r_outstanding;
    logic [OW-1:0]                  r_drop_cnt;
    logic [31:0]                    r_redirect_cnt;

    logic [ISSUE_NUM-1:0]           w_cond;
    logic [ISSUE_NUM-1:0]           w_cand;
    logic [ISSUE_NUM-1:0]           w_slot_taken;
    logic [ISSUE_NUM-1:0][XLEN-1:0] w_slot_target;
    logic                           w_found;
    logic                           w_taken;
    logic [XLEN-1:0]                w_target;
    logic [ISSUE_NUM-1:0]           w_kill;
    logic                           w_req;
    logic                           w_accept;
    logic                           w_resp_dec;
    logic                           w_drop;
    logic                           w_redirect;
    redirect_src_e                  w_src;
    logic                           w_unused_resp_cnt;

    // resp_cnt is informational: sequential fetch always advances a full FETCH_NUM group
    assign w_unused_resp_cnt = ^resp_cnt;

    for (genvar g = 0; g < ISSUE_NUM; g++) begin : g_slot
        branch_cond_eval #(.XLEN(XLEN)) u_cond (
            .i_funct3 (funct3[g*3 +: 3]),
            .i_rs1    (rs_data1[g*XLEN +: XLEN]),
            .i_rs2    (rs_data2[g*XLEN +: XLEN]),
            .o_taken  (w_cond[g])
        );
        assign w_cand[g]        = issue_en[g] & (is_b[g] | is_j[g] | is_jr[g]);
        assign w_slot_taken[g]  = is_j[g] | is_jr[g] | (is_b[g] & w_cond[g]);
        assign w_slot_target[g] = is_jr[g]
            ? ((rs_data1[g*XLEN +: XLEN] + imm[g*XLEN +: XLEN]) & LSB_CLR)
            : (slot_pc[g*XLEN +: XLEN] + imm[g*XLEN +: XLEN]);
    end

    // Oldest control-transfer slot decides; younger slots are killed only when it is taken
    always_comb begin
        w_found  = 1'b0;
        w_taken  = 1'b0;
        w_target = '0;
        w_kill   = '0;
        for (int i = 0; i < ISSUE_NUM; i++) begin
            if (!w_found && w_cand[i]) begin
                w_found  = 1'b1;
                w_taken  = w_slot_taken[i];
                w_target = w_slot_target[i];
                for (int j = i + 1; j < ISSUE_NUM; j++) begin
                    w_kill[j] = w_slot_taken[i];
                end
            end else begin
                w_found = w_found;
            end
        end
    end

    // No request may issue from a PC that is about to be replaced
    assign w_req      = rst_n & ~fifo_full & (r_outstanding < OW'(MAX_OUTSTANDING))
                        & ~trap_valid & ~w_taken;
    assign w_accept   = w_req & imem_ready;
    assign w_resp_dec = resp_valid & (r_outstanding != '0);
    assign w_drop     = resp_valid & (r_drop_cnt != '0);

    // Next-PC source arbitration; a misaligned taken target holds the PC for trap handling
    always_comb begin
        if (trap_valid) begin
            w_src = TRAP;
        end else if (w_taken) begin
            w_src = w_target[1] ? HOLD : ID;
        end else if (fifo_full) begin
            w_src = HOLD;
        end else if (w_accept) begin
            w_src = SEQ;
        end else begin
            w_src = NONE;
        end
    end

    assign w_redirect = (w_src == TRAP) | (w_src == ID);

    // PC, in-flight tracking and redirect statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc           <= RST_PC;
            r_outstanding  <= '0;
            r_drop_cnt     <= '0;
            r_redirect_cnt <= 32'd0;
        end else begin
            case (w_src)
                TRAP:    r_pc <= trap_pc;
                ID:      r_pc <= w_target;
                SEQ:     r_pc <= r_pc + PC_STEP;
                default: r_pc <= r_pc;
            endcase

            case ({w_accept, w_resp_dec})
                2'b10:   r_outstanding <= r_outstanding + OW'(1);
                2'b01:   r_outstanding <= r_outstanding - OW'(1);
                default: r_outstanding <= r_outstanding;
            endcase

            if (w_redirect) begin
                r_drop_cnt     <= r_outstanding - OW'(w_resp_dec);
                r_redirect_cnt <= sat_inc32(r_redirect_cnt);
            end else if (w_drop) begin
                r_drop_cnt     <= r_drop_cnt - OW'(1);
                r_redirect_cnt <= r_redirect_cnt;
            end else begin
                r_drop_cnt     <= r_drop_cnt;
                r_redirect_cnt <= r_redirect_cnt;
            end
        end
    end

    assign imem_req       = w_req;
    assign fetch_pc       = r_pc;
    assign resp_drop      = w_drop;
    assign id_is_transfer = rst_n & w_taken;
    assign kill_mask      = w_kill & {ISSUE_NUM{rst_n}};
    assign misalign       = rst_n & w_taken & w_target[1];
    assign redirect_cnt   = r_redirect_cnt;

endmodule
